// File: rtl/reduction_drain_pkg.sv
// ---------------------------------------------------------------------------
// reduction_drain_pkg
// Shared constants, element type and FSM state encoding for the FP16 tile
// reduction drain (reduction_drain, reduction_drain_ser, reduction_drain_if).
//   WIDTH      element width (FP16)
//   TILE_SIZE  accumulator lanes per tile
//   OUT_LANES  elements per output beat
//   STEP_W     width of the per-tile step count
//   BEATS      output beats per tile, ceil(TILE_SIZE/OUT_LANES)
// ---------------------------------------------------------------------------
package reduction_drain_pkg;

  localparam int WIDTH     = 16;
  localparam int TILE_SIZE = 129;
  localparam int OUT_LANES = 8;
  localparam int STEP_W    = 16;

  typedef logic [WIDTH-1:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } drain_state_e;

  function automatic int calc_beats(input int tile, input int lanes);
    return (tile + lanes - 1) / lanes;
  endfunction

  localparam int BEATS = calc_beats(TILE_SIZE, OUT_LANES);

  // Lanes of the final beat that carry real tile elements; the rest are padding.
  function automatic logic [OUT_LANES-1:0] last_beat_mask();
    logic [OUT_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      if (i < TILE_SIZE - (BEATS - 1) * OUT_LANES) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/reduction_drain_if.sv
// ---------------------------------------------------------------------------
// reduction_drain_if
// Valid/ready output stream from the drain toward writeback.
//   valid  beat valid                      (master -> slave)
//   ready  downstream accept               (slave  -> master)
//   data   OUT_LANES x FP16 elements       (master -> slave)
//   mask   lane-valid mask                 (master -> slave)
//   last   final beat of the tile          (master -> slave)
// ---------------------------------------------------------------------------
interface reduction_drain_if import reduction_drain_pkg::*; ();

  logic                       valid;
  logic                       ready;
  logic [OUT_LANES*WIDTH-1:0] data;
  logic [OUT_LANES-1:0]       mask;
  logic                       last;

  modport master (output valid, output data, output mask, output last, input ready);
  modport slave  (input valid, input data, input mask, input last, output ready);

endinterface

// File: rtl/reduction_drain_ser.sv
// ---------------------------------------------------------------------------
// reduction_drain_ser
// Shadow register plus beat serializer. A capture pulse snapshots the whole
// accumulator vector; the snapshot is then streamed as BEATS beats of
// OUT_LANES elements. Optional ReLU on the output path when
// REDUCTION_DRAIN_RELU_EN is defined (shadow contents stay unmodified).
// Ports:
//   clk, rst_n    clock, async active-low reset
//   capture_i     load shadow from reduction_i (only issued while empty)
//   reduction_i   accumulator vector, TILE_SIZE*WIDTH
//   full_o        shadow holds a tile not yet fully drained
//   out_if        output stream (master)
// ---------------------------------------------------------------------------
module reduction_drain_ser
  import reduction_drain_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       capture_i,
  input  logic [TILE_SIZE*WIDTH-1:0] reduction_i,
  output logic                       full_o,
  reduction_drain_if.master          out_if
);

  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BITS = OUT_LANES * WIDTH;
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [OUT_LANES-1:0] LAST_MASK = last_beat_mask();

  logic [BEATS-1:0][BEAT_BITS-1:0] shadow;
  logic                            full;
  logic [BEAT_W-1:0]               beat;
  logic                            accept;
  logic [BEAT_BITS-1:0]            cur_beat;

  assign accept   = full && out_if.ready;
  assign cur_beat = shadow[beat];
  assign full_o   = full;

  function automatic fp16_t drain_elem(input fp16_t e);
`ifdef REDUCTION_DRAIN_RELU_EN
    return e[WIDTH-1] ? '0 : e;
`else
    return e;
`endif
  endfunction

  // Snapshot storage. Zero-extension pads the lanes past TILE_SIZE so the
  // partial final beat carries zeros. No reset: data is gated by full.
  always_ff @(posedge clk) begin
    if (capture_i) begin
      shadow <= (BEATS * BEAT_BITS)'(reduction_i);
    end
  end

  // Occupancy and beat pointer. The accepted last beat frees the shadow on
  // the same edge; a refill can only arrive on a later edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      beat <= '0;
    end else if (capture_i) begin
      full <= 1'b1;
      beat <= '0;
    end else if (accept) begin
      if (beat == LAST_BEAT) begin
        full <= 1'b0;
        beat <= '0;
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  // Output beat driven straight from registered state, so it stays stable
  // for as long as the consumer stalls.
  always_comb begin
    out_if.valid = full;
    out_if.data  = '0;
    out_if.mask  = '0;
    out_if.last  = 1'b0;
    if (full) begin
      out_if.last = (beat == LAST_BEAT);
      out_if.mask = (beat == LAST_BEAT) ? LAST_MASK : '1;
      for (int k = 0; k < OUT_LANES; k++) begin
        out_if.data[k*WIDTH +: WIDTH] = drain_elem(cur_beat[k*WIDTH +: WIDTH]);
      end
    end
  end

endmodule

// File: rtl/reduction_drain.sv
// ---------------------------------------------------------------------------
// reduction_drain
// Downstream companion of the FP16 tile reduction stage. Counts accumulation
// steps per tile, snapshots the finished accumulator into a shadow register,
// pulses the accumulator clear, and serializes the tile toward writeback.
// The next tile may accumulate while the previous one drains.
// Optional feature: REDUCTION_DRAIN_RELU_EN (negative elements emitted as 0).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start_i         begin a tile (sampled while start_ready_o)
//   num_steps_i     operand groups in the tile, latched with start_i
//   start_ready_o   accumulation FSM idle
//   step_valid_i    reduction stage consumed an operand group
//   reduction_i     accumulator vector from the reduction stage
//   acc_clear_o     registered 1-cycle clear pulse to the reduction stage
//   busy_o          a tile is accumulating, held or draining
//   out_if          output beat stream (master)
// ---------------------------------------------------------------------------
module reduction_drain
  import reduction_drain_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [STEP_W-1:0]          num_steps_i,
  output logic                       start_ready_o,
  input  logic                       step_valid_i,
  input  logic [TILE_SIZE*WIDTH-1:0] reduction_i,
  output logic                       acc_clear_o,
  output logic                       busy_o,
  reduction_drain_if.master          out_if
);

  drain_state_e      state, state_next;
  logic [STEP_W-1:0] step_cnt, step_cnt_next;
  logic [STEP_W-1:0] num_steps, num_steps_next;
  logic              capture;
  logic              acc_clear_q;
  logic              shadow_full;

  // State, step counter, latched step count and the clear pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step_cnt    <= '0;
      num_steps   <= '0;
      acc_clear_q <= 1'b0;
    end else begin
      state       <= state_next;
      step_cnt    <= step_cnt_next;
      num_steps   <= num_steps_next;
      acc_clear_q <= capture;
    end
  end

  // Next-state logic. SETTLE gives the accumulator register one cycle to
  // absorb the last add. CAPTURE only looks at the registered shadow flag,
  // so a tile finishing alongside the last accepted beat waits one cycle.
  always_comb begin
    state_next     = state;
    step_cnt_next  = step_cnt;
    num_steps_next = num_steps;
    capture        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          num_steps_next = num_steps_i;
          step_cnt_next  = '0;
          state_next     = (num_steps_i == '0) ? SETTLE : ACCUM;
        end
      end
      ACCUM: begin
        if (step_valid_i) begin
          if (step_cnt == num_steps - STEP_W'(1)) begin
            state_next = SETTLE;
          end else begin
            step_cnt_next = step_cnt + STEP_W'(1);
          end
        end
      end
      SETTLE: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        if (!shadow_full) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign start_ready_o = (state == IDLE);
  assign acc_clear_o   = acc_clear_q;
  assign busy_o        = (state != IDLE) || shadow_full;

  reduction_drain_ser u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture_i   (capture),
    .reduction_i (reduction_i),
    .full_o      (shadow_full),
    .out_if      (out_if)
  );

endmodule
